// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that wraps user output words into BFT packets.
// Each port is gated by its destination configuration and its remaining receiver credit.
module leaf_out_arbiter #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_OUT_PORTS      = 2,
  parameter int NUM_BRAM_ADDR_BITS = 7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [NUM_BRAM_ADDR_BITS:0]           credit_amt,
  input  logic                                  hold,
  input  logic [NUM_OUT_PORTS-1:0]              vld_req,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_req,
  output logic [NUM_OUT_PORTS-1:0]              ack_req,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  output logic                                  credit_err
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_BITS    = CREDIT_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(2 ** NUM_BRAM_ADDR_BITS);

  logic [NUM_OUT_PORTS-1:0] cfgd_q;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] ptr_q, ptr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     credit_err_q, credit_err_d;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     grant_any;
  logic [NUM_PORT_BITS-1:0] grant_idx;
  logic [SUM_BITS-1:0]      sum;
  int                       idx;

  always_comb begin
    elig = '0;
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      elig[j] = vld_req[j] & cfgd_q[j] & (credit_q[j] != '0) & ~hold & ~reset;
    end
  end

  // Scan from the pointer and take the first eligible port; this rotation prevents starvation.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_OUT_PORTS;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = NUM_PORT_BITS'(idx);
      end
    end
    grant = '0;
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      grant[j] = grant_any && (grant_idx == NUM_PORT_BITS'(j));
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    dout_d = '0;
    if (grant_any) begin
      ptr_d = (grant_idx == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      if (grant[j]) begin
        dout_d = {1'b1, leaf_q[j], port_q[j], seq_q[j], din_req[j*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // A grant and a return on the same port net out before the saturation check.
  always_comb begin
    credit_err_d = credit_err_q;
    sum          = '0;
    if (credit_vld && (credit_port == '0 || int'(credit_port) > NUM_OUT_PORTS)) begin
      credit_err_d = 1'b1;
    end
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      sum = SUM_BITS'(credit_q[j]) - SUM_BITS'(grant[j]);
      if (credit_vld && credit_port == NUM_PORT_BITS'(j + 1)) begin
        sum = sum + SUM_BITS'(credit_amt);
      end
      if (sum > SUM_BITS'(CREDIT_MAX)) begin
        credit_d[j]  = CREDIT_MAX;
        credit_err_d = 1'b1;
      end else begin
        credit_d[j] = sum[CREDIT_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfgd_q       <= '0;
      ptr_q        <= '0;
      dout_q       <= '0;
      credit_err_q <= 1'b0;
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
        leaf_q[j]   <= '0;
        port_q[j]   <= '0;
        seq_q[j]    <= '0;
        credit_q[j] <= CREDIT_MAX;
      end
    end else begin
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      credit_err_q <= credit_err_d;
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
        credit_q[j] <= credit_d[j];
        if (grant[j]) begin
          seq_q[j] <= seq_q[j] + 1'b1;
        end
        if (cfg_wr_en && cfg_port == NUM_PORT_BITS'(j + 1)) begin
          cfgd_q[j] <= 1'b1;
          leaf_q[j] <= cfg_dest_leaf;
          port_q[j] <= cfg_dest_port;
        end
      end
    end
  end

  assign ack_req    = grant;
  assign dout_pkt   = dout_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: vector table plus directed sequences.
// Expected packets queue up when a cycle is driven and are popped after the edge.
module tb_leaf_out_arbiter;

  logic        clk;
  logic        reset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_port;
  logic [4:0]  cfg_dest_leaf;
  logic [3:0]  cfg_dest_port;
  logic        credit_vld;
  logic [3:0]  credit_port;
  logic [7:0]  credit_amt;
  logic        hold;
  logic [1:0]  vld_req;
  logic [63:0] din_req;
  logic [1:0]  ack_req;
  logic [48:0] dout_pkt;
  logic        credit_err;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        hld;
    logic [1:0]  expAck;
    logic [48:0] expPkt;
  } vecT;

  vecT         vecs[8];
  logic [48:0] expQ[$];
  int          checks = 0;
  int          passed = 0;

  leaf_out_arbiter dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_port(cfg_port),
    .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_amt(credit_amt),
    .hold(hold), .vld_req(vld_req), .din_req(din_req),
    .ack_req(ack_req), .dout_pkt(dout_pkt), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mkPkt(input logic [4:0] lf, input logic [3:0] pt,
                                        input logic [6:0] sq, input logic [31:0] w);
    return {1'b1, lf, pt, sq, w};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one cycle; ack is checked just before the edge, the packet just after it.
  task automatic applyStimulus(input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                               input logic hld, input logic [1:0] expAck,
                               input logic [48:0] expPkt, input string name);
    logic [48:0] exp;
    @(negedge clk);
    vld_req = vld;
    din_req = {d1, d0};
    hold    = hld;
    expQ.push_back(expPkt);
    #4;
    checkOutput({name, " ack"}, 64'(ack_req), 64'(expAck));
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput({name, " pkt"}, 64'(dout_pkt), 64'(exp));
    cfg_wr_en  = 1'b0;
    credit_vld = 1'b0;
  endtask

  task automatic idle(input string name);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 49'h0, name);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle("reset");
    reset = 1'b0;
  endtask

  task automatic cfgPort(input logic [3:0] p, input logic [4:0] lf, input logic [3:0] pt);
    cfg_wr_en     = 1'b1;
    cfg_port      = p;
    cfg_dest_leaf = lf;
    cfg_dest_port = pt;
    idle("cfg");
  endtask

  task automatic setCredit(input logic [3:0] p, input logic [7:0] amt);
    credit_vld  = 1'b1;
    credit_port = p;
    credit_amt  = amt;
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    credit_vld = 1'b0; credit_port = '0; credit_amt = '0; hold = 1'b0;
    vld_req = '0; din_req = '0;

    vecs[0] = '{2'b11, 32'h1111_0000, 32'h2222_0000, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd0, 32'h1111_0000)};
    vecs[1] = '{2'b11, 32'h1111_0001, 32'h2222_0001, 1'b0, 2'b10, mkPkt(5'd9, 4'd7, 7'd0, 32'h2222_0001)};
    vecs[2] = '{2'b11, 32'h1111_0002, 32'h2222_0002, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd1, 32'h1111_0002)};
    vecs[3] = '{2'b11, 32'h1111_0003, 32'h2222_0003, 1'b0, 2'b10, mkPkt(5'd9, 4'd7, 7'd1, 32'h2222_0003)};
    vecs[4] = '{2'b11, 32'h1111_0004, 32'h2222_0004, 1'b1, 2'b00, 49'h0};
    vecs[5] = '{2'b11, 32'h1111_0005, 32'h2222_0005, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd2, 32'h1111_0005)};
    vecs[6] = '{2'b10, 32'h1111_0006, 32'h2222_0006, 1'b0, 2'b10, mkPkt(5'd9, 4'd7, 7'd2, 32'h2222_0006)};
    vecs[7] = '{2'b01, 32'h1111_0007, 32'h2222_0007, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd3, 32'h1111_0007)};

    idle("reset0");
    doReset();
    checkOutput("reset err", 64'(credit_err), 64'(0));

    // Unconfigured ports, out-of-range cfg writes, then single-port traffic
    applyStimulus(2'b11, 32'h1, 32'h2, 1'b0, 2'b00, 49'h0, "unconfigured");
    cfgPort(4'd3, 5'd1, 4'd1);
    cfgPort(4'd0, 5'd1, 4'd1);
    applyStimulus(2'b11, 32'h1, 32'h2, 1'b0, 2'b00, 49'h0, "bad cfg index");
    cfgPort(4'd1, 5'd5, 4'd3);
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd0, 32'hDEAD_BEEF), "T1");
    applyStimulus(2'b10, 32'h0, 32'h5555_5555, 1'b0, 2'b00, 49'h0, "port2 unconfigured");
    applyStimulus(2'b01, 32'h1234_5678, 32'h0, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd1, 32'h1234_5678), "T1 seq1");

    // Round robin with a hold gap
    doReset();
    cfgPort(4'd1, 5'd5, 4'd3);
    cfgPort(4'd2, 5'd9, 4'd7);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].hld, vecs[i].expAck, vecs[i].expPkt, "vec");
    end

    // Reset mid-stream clears config, pointer and sequence numbers
    reset = 1'b1;
    applyStimulus(2'b11, 32'hAAAA_0000, 32'hBBBB_0000, 1'b0, 2'b00, 49'h0, "T6 reset");
    reset = 1'b0;
    applyStimulus(2'b11, 32'hAAAA_0001, 32'hBBBB_0001, 1'b0, 2'b00, 49'h0, "T6 no cfg");
    cfgPort(4'd1, 5'd5, 4'd3);
    cfgPort(4'd2, 5'd9, 4'd7);
    applyStimulus(2'b11, 32'hAAAA_0002, 32'hBBBB_0002, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd0, 32'hAAAA_0002), "T6 restart");
    cfg_wr_en = 1'b1; cfg_port = 4'd2; cfg_dest_leaf = 5'd12; cfg_dest_port = 4'd2;
    applyStimulus(2'b11, 32'hAAAA_0003, 32'hBBBB_0003, 1'b0, 2'b10, mkPkt(5'd9, 4'd7, 7'd0, 32'hBBBB_0003), "cfg old dest");
    applyStimulus(2'b10, 32'hAAAA_0004, 32'hBBBB_0004, 1'b0, 2'b10, mkPkt(5'd12, 4'd2, 7'd1, 32'hBBBB_0004), "cfg new dest");

    // Credit exhaustion and return
    doReset();
    cfgPort(4'd1, 5'd5, 4'd3);
    for (int i = 0; i < 128; i++) begin
      applyStimulus(2'b01, 32'hA000_0000 + 32'(i), 32'h0, 1'b0, 2'b01,
                    mkPkt(5'd5, 4'd3, 7'(i), 32'hA000_0000 + 32'(i)), "T3 send");
    end
    applyStimulus(2'b01, 32'hB000_0000, 32'h0, 1'b0, 2'b00, 49'h0, "T3 no credit");
    setCredit(4'd1, 8'd4);
    applyStimulus(2'b01, 32'hB000_0001, 32'h0, 1'b0, 2'b00, 49'h0, "T3 return cycle");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 32'hC000_0000 + 32'(i), 32'h0, 1'b0, 2'b01,
                    mkPkt(5'd5, 4'd3, 7'(i), 32'hC000_0000 + 32'(i)), "T3 refill");
    end
    applyStimulus(2'b01, 32'hB000_0002, 32'h0, 1'b0, 2'b00, 49'h0, "T3 empty again");
    checkOutput("T3 err", 64'(credit_err), 64'(0));

    // Same-cycle grant and return, then saturation
    setCredit(4'd1, 8'd1);
    idle("T4 credit1");
    setCredit(4'd1, 8'd2);
    applyStimulus(2'b01, 32'hD000_0004, 32'h0, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd4, 32'hD000_0004), "T4 grant+ret");
    applyStimulus(2'b01, 32'hD000_0005, 32'h0, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd5, 32'hD000_0005), "T4 use1");
    applyStimulus(2'b01, 32'hD000_0006, 32'h0, 1'b0, 2'b01, mkPkt(5'd5, 4'd3, 7'd6, 32'hD000_0006), "T4 use2");
    applyStimulus(2'b01, 32'hD000_0007, 32'h0, 1'b0, 2'b00, 49'h0, "T4 empty");
    checkOutput("T4 err before", 64'(credit_err), 64'(0));
    setCredit(4'd1, 8'd2);
    idle("T4 credit2");
    setCredit(4'd1, 8'd128);
    idle("T4 overflow");
    checkOutput("T4 sat err", 64'(credit_err), 64'(1));
    for (int i = 0; i < 128; i++) begin
      applyStimulus(2'b01, 32'hE000_0000 + 32'(i), 32'h0, 1'b0, 2'b01,
                    mkPkt(5'd5, 4'd3, 7'(i + 7), 32'hE000_0000 + 32'(i)), "T4 drain");
    end
    applyStimulus(2'b01, 32'hE000_FFFF, 32'h0, 1'b0, 2'b00, 49'h0, "T4 saturated at 128");
    checkOutput("T4 err sticky", 64'(credit_err), 64'(1));

    // Invalid credit ports and full-credit boundaries
    doReset();
    checkOutput("err cleared", 64'(credit_err), 64'(0));
    setCredit(4'd3, 8'd1);
    idle("bad port3");
    checkOutput("err port3", 64'(credit_err), 64'(1));
    doReset();
    setCredit(4'd0, 8'd1);
    idle("bad port0");
    checkOutput("err port0", 64'(credit_err), 64'(1));
    doReset();
    setCredit(4'd2, 8'd0);
    idle("amt0 at full");
    checkOutput("err amt0", 64'(credit_err), 64'(0));
    setCredit(4'd2, 8'd1);
    idle("amt1 at full");
    checkOutput("err amt1", 64'(credit_err), 64'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
